uc_rr_collector: RTL and testbench

- Parametrised next-generation unit-clause collector between the per-engine implied-literal queues (UCQ_IN) and the broadcast path to engine UCQ_OUT.
- Each cycle it grants at most one source: the memory/interconnect port first, then one of NUM_ENG engines.
- Granted literals are buffered in a DEPTH-entry FIFO, checked against buffered entries for complementary-literal conflicts, and broadcast from the FIFO head when no engine is full.

---
 rtl/uc_rr_collector_pkg.sv | 18 +
 rtl/uc_rr_collector_if.sv | 33 +++
 rtl/uc_rr_collector_cam_fifo.sv | 84 ++++++++
 rtl/uc_rr_collector.sv | 107 ++++++++++
 tb/tb_uc_rr_collector.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uc_rr_collector_pkg.sv
// Shared literal type and helpers for the unit-clause collector.
// Bit LIT_W-1 is polarity (1 = negated); the low bits are the variable index.
package uc_pkg;

    localparam int DEF_LIT_W = 16;
    localparam int NULL_IDX  = 0;

    typedef logic [DEF_LIT_W-1:0] lit_t;

    function automatic logic [DEF_LIT_W-2:0] lit_idx(input lit_t l);
        return l[DEF_LIT_W-2:0];
    endfunction

    function automatic logic lit_neg(input lit_t l);
        return l[DEF_LIT_W-1];
    endfunction

endpackage

// File: rtl/uc_rr_collector_if.sv
// Handshake bundle between the engine/memory sources, the broadcast sinks and the collector.
interface uc_rr_collector_if #(
    parameter int NUM_ENG = 4,
    parameter int LIT_W   = 16,
    parameter int DEPTH   = 8
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                     flush;
    logic                     mode;
    logic                     mem_valid;
    logic [LIT_W-1:0]         mem_lit;
    logic                     mem_ready;
    logic [NUM_ENG-1:0]       eng_valid;
    logic [NUM_ENG*LIT_W-1:0] eng_lit;
    logic [NUM_ENG-1:0]       eng_pop;
    logic [NUM_ENG:0]         eng_full;
    logic [LIT_W-1:0]         out_lit;
    logic                     out_push;
    logic                     conflict;
    logic [CNT_W-1:0]         count;

    modport master (
        output flush, mode, mem_valid, mem_lit, eng_valid, eng_lit, eng_full,
        input  mem_ready, eng_pop, out_lit, out_push, conflict, count
    );

    modport slave (
        input  flush, mode, mem_valid, mem_lit, eng_valid, eng_lit, eng_full,
        output mem_ready, eng_pop, out_lit, out_push, conflict, count
    );

endinterface

// File: rtl/uc_rr_collector_cam_fifo.sv
// DEPTH-entry literal FIFO with parallel same/complement match against a probe literal.
// Non-power-of-two depths are supported; pointers wrap explicitly.
module uc_cam_fifo #(
    parameter int DEPTH = 8,
    parameter int LIT_W = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_wr,
    input  logic [LIT_W-1:0] i_wdata,
    input  logic             i_rd,
    input  logic [LIT_W-1:0] i_probe,
    output logic [LIT_W-1:0] o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_hit_same,
    output logic             o_hit_comp
);

    logic [LIT_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Clear before set so a same-slot read and write at full leaves the slot valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_vld    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_rd) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= ptr_inc(r_rd_ptr);
            end
            if (i_wr) begin
                r_vld[r_wr_ptr] <= 1'b1;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            case ({i_wr, i_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_comb begin
        o_hit_same = 1'b0;
        o_hit_comp = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && (r_mem[i][LIT_W-2:0] == i_probe[LIT_W-2:0])) begin
                if (r_mem[i][LIT_W-1] == i_probe[LIT_W-1]) begin
                    o_hit_same = 1'b1;
                end else begin
                    o_hit_comp = 1'b1;
                end
            end
        end
    end

    assign o_head  = r_vld[r_rd_ptr] ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/uc_rr_collector.sv
// Unit-clause collector: grants memory first, then engines round-robin, into a conflict-checked FIFO.
// Define UCA_DEDUP_EN to drop granted literals identical to one already buffered.
module uc_rr_collector
    import uc_pkg::*;
#(
    parameter int NUM_ENG = 4,
    parameter int LIT_W   = DEF_LIT_W,
    parameter int DEPTH   = 8
) (
    input logic              clk,
    input logic              rst,
    uc_rr_collector_if.slave bus
);

    localparam int PTR_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef UCA_DEDUP_EN
    localparam bit DEDUP_EN = 1'b1;
`else
    localparam bit DEDUP_EN = 1'b0;
`endif

    logic [PTR_W-1:0] r_rr_ptr;
    logic             r_conflict;

    logic [LIT_W-1:0] w_head;
    logic [CNT_W-1:0] w_count;
    logic             w_hit_same;
    logic             w_hit_comp;
    logic             w_push;
    logic             w_accept;
    logic             w_eng_hit;
    logic [PTR_W-1:0] w_gnt_idx;
    logic             w_mem_gnt;
    logic             w_eng_gnt;
    logic [LIT_W-1:0] w_glit;
    logic             w_null;
    logic             w_wr;

    // Grants are held off while rst is asserted so every output reads 0 in reset.
    assign w_push   = (w_count != '0) && !(|bus.eng_full) && !r_conflict && !bus.flush;
    assign w_accept = ((w_count < CNT_W'(DEPTH)) || w_push) && !r_conflict && !bus.flush && rst;

    always_comb begin
        w_eng_hit = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < NUM_ENG; k++) begin
            if (!w_eng_hit && bus.eng_valid[(int'(r_rr_ptr) + k) % NUM_ENG]) begin
                w_eng_hit = 1'b1;
                w_gnt_idx = PTR_W'((int'(r_rr_ptr) + k) % NUM_ENG);
            end
        end
    end

    assign w_mem_gnt = w_accept && bus.mem_valid;
    assign w_eng_gnt = w_accept && !bus.mem_valid && w_eng_hit;
    assign w_glit    = w_mem_gnt ? bus.mem_lit : bus.eng_lit[int'(w_gnt_idx)*LIT_W +: LIT_W];
    assign w_null    = (w_glit[LIT_W-2:0] == (LIT_W-1)'(NULL_IDX));
    assign w_wr      = (w_mem_gnt || w_eng_gnt) && !w_null && !w_hit_comp
                       && !(DEDUP_EN && w_hit_same);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr   <= '0;
            r_conflict <= 1'b0;
        end else if (bus.flush) begin
            r_rr_ptr   <= '0;
            r_conflict <= 1'b0;
        end else begin
            if ((w_mem_gnt || w_eng_gnt) && !w_null && w_hit_comp) begin
                r_conflict <= 1'b1;
            end
            if (w_eng_gnt) begin
                if (bus.mode) begin
                    r_rr_ptr <= (int'(w_gnt_idx) == NUM_ENG - 1) ? '0 : w_gnt_idx + 1'b1;
                end else begin
                    r_rr_ptr <= w_gnt_idx;
                end
            end
        end
    end

    uc_cam_fifo #(
        .DEPTH (DEPTH),
        .LIT_W (LIT_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (bus.flush),
        .i_wr       (w_wr),
        .i_wdata    (w_glit),
        .i_rd       (w_push),
        .i_probe    (w_glit),
        .o_head     (w_head),
        .o_count    (w_count),
        .o_hit_same (w_hit_same),
        .o_hit_comp (w_hit_comp)
    );

    assign bus.mem_ready = w_mem_gnt;
    assign bus.eng_pop   = w_eng_gnt ? (NUM_ENG'(1) << w_gnt_idx) : '0;
    assign bus.out_lit   = w_head;
    assign bus.out_push  = w_push;
    assign bus.conflict  = r_conflict;
    assign bus.count     = w_count;

endmodule

// File: tb/tb_uc_rr_collector.sv
// Directed bench for uc_rr_collector with a queue-based reference model checked every cycle.
module tb_uc_rr_collector;
    import uc_pkg::*;

    localparam int NE = 4;
    localparam int LW = 16;
    localparam int DP = 8;
`ifdef UCA_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uc_rr_collector_if #(.NUM_ENG(NE), .LIT_W(LW), .DEPTH(DP)) bus ();

    uc_rr_collector #(.NUM_ENG(NE), .LIT_W(LW), .DEPTH(DP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Source queues the bench plays back as UCQ_IN / memory port.
    lit_t mem_q[$];
    lit_t eng_q[NE][$];
    logic flush_v = 1'b0;
    logic mode_v  = 1'b0;
    logic [NE:0] full_v = '0;

    // Model state: FIFO contents, sticky conflict, search start.
    lit_t m_fifo[$];
    logic m_conf = 1'b0;
    int   m_ptr  = 0;

    logic [NE-1:0] pop_log[$];
    bit            mr_log[$];
    bit            pu_log[$];
    lit_t          lit_log[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic apply();
        bus.flush     = flush_v;
        bus.mode      = mode_v;
        bus.eng_full  = full_v;
        bus.mem_valid = (mem_q.size() != 0);
        bus.mem_lit   = (mem_q.size() != 0) ? mem_q[0] : '0;
        for (int e = 0; e < NE; e++) begin
            bus.eng_valid[e]         = (eng_q[e].size() != 0);
            bus.eng_lit[e*LW +: LW]  = (eng_q[e].size() != 0) ? eng_q[e][0] : '0;
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            apply();
        end
    endtask

    task automatic do_flush();
        flush_v = 1'b1;
        apply();
        @(posedge clk);
        #1;
        flush_v = 1'b0;
        apply();
    endtask

    task automatic clear_logs();
        pop_log.delete();
        mr_log.delete();
        pu_log.delete();
        lit_log.delete();
    endtask

    function automatic int n_pushes();
        int s = 0;
        foreach (pu_log[i]) s += int'(pu_log[i]);
        return s;
    endfunction

    function automatic int n_pops();
        int s = 0;
        foreach (pop_log[i]) s += int'(pop_log[i] != '0);
        return s;
    endfunction

    // Compare process: predicts this cycle's outputs from the model, then advances the model.
    logic          e_push, e_acc, e_mr, has, same, comp;
    int            e_g;
    logic [NE-1:0] e_pop;
    lit_t          g_lit;
    always @(negedge clk) begin
        if (rst) begin
            e_push = (m_fifo.size() != 0) && (full_v == '0) && !m_conf && !flush_v;
            e_acc  = ((m_fifo.size() < DP) || e_push) && !m_conf && !flush_v;
            e_mr   = e_acc && (mem_q.size() != 0);
            e_g    = -1;
            if (e_acc && !e_mr) begin
                for (int k = 0; k < NE; k++) begin
                    if (e_g < 0 && eng_q[(m_ptr + k) % NE].size() != 0) e_g = (m_ptr + k) % NE;
                end
            end
            e_pop = (e_g >= 0) ? NE'(1 << e_g) : '0;

            chk("mem_ready", 64'(bus.mem_ready), 64'(e_mr));
            chk("eng_pop",   64'(bus.eng_pop),   64'(e_pop));
            chk("out_push",  64'(bus.out_push),  64'(e_push));
            chk("out_lit",   64'(bus.out_lit),   64'((m_fifo.size() != 0) ? m_fifo[0] : lit_t'(0)));
            chk("count",     64'(bus.count),     64'(m_fifo.size()));
            chk("conflict",  64'(bus.conflict),  64'(m_conf));

            pop_log.push_back(bus.eng_pop);
            mr_log.push_back(bus.mem_ready);
            pu_log.push_back(bus.out_push);
            if (bus.out_push) lit_log.push_back(bus.out_lit);

            if (flush_v) begin
                m_fifo.delete();
                m_conf = 1'b0;
                m_ptr  = 0;
            end else begin
                has   = 1'b0;
                g_lit = '0;
                if (e_mr) begin
                    g_lit = mem_q.pop_front();
                    has   = 1'b1;
                end else if (e_g >= 0) begin
                    g_lit = eng_q[e_g].pop_front();
                    has   = 1'b1;
                    m_ptr = mode_v ? (e_g + 1) % NE : e_g;
                end
                same = 1'b0;
                comp = 1'b0;
                if (has && lit_idx(g_lit) != '0) begin
                    foreach (m_fifo[i]) begin
                        if (lit_idx(m_fifo[i]) == lit_idx(g_lit)) begin
                            if (lit_neg(m_fifo[i]) == lit_neg(g_lit)) same = 1'b1;
                            else comp = 1'b1;
                        end
                    end
                end
                if (e_push) void'(m_fifo.pop_front());
                if (comp) m_conf = 1'b1;
                else if (has && lit_idx(g_lit) != '0 && !(DEDUP && same)) m_fifo.push_back(g_lit);
            end
        end
    end

    initial begin
        // Reset: all outputs 0 even with every source asserting.
        bus.flush     = 1'b0;
        bus.mode      = 1'b1;
        bus.mem_valid = 1'b1;
        bus.mem_lit   = 16'h0003;
        bus.eng_valid = '1;
        bus.eng_lit   = 64'h0004_0003_0002_0001;
        bus.eng_full  = '0;
        #12;
        chk("rst_mem_ready", 64'(bus.mem_ready), 64'd0);
        chk("rst_eng_pop",   64'(bus.eng_pop),   64'd0);
        chk("rst_out_push",  64'(bus.out_push),  64'd0);
        chk("rst_out_lit",   64'(bus.out_lit),   64'd0);
        chk("rst_count",     64'(bus.count),     64'd0);
        chk("rst_conflict",  64'(bus.conflict),  64'd0);
        apply();
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Round-robin fairness: 0,1,2,3,0 on consecutive cycles; first push one cycle later.
        mode_v = 1'b1;
        eng_q[0] = '{16'h0011, 16'h0015};
        eng_q[1] = '{16'h0012};
        eng_q[2] = '{16'h0013};
        eng_q[3] = '{16'h0014};
        apply();
        clear_logs();
        cyc(6);
        chk("rr_pop0", 64'(pop_log[0]), 64'h1);
        chk("rr_pop1", 64'(pop_log[1]), 64'h2);
        chk("rr_pop2", 64'(pop_log[2]), 64'h4);
        chk("rr_pop3", 64'(pop_log[3]), 64'h8);
        chk("rr_pop4", 64'(pop_log[4]), 64'h1);
        chk("rr_push_t0", 64'(pu_log[0]), 64'd0);
        chk("rr_push_t1", 64'(pu_log[1]), 64'd1);

        // Sequential drain: engine 1 three times, then engine 2.
        do_flush();
        mode_v = 1'b0;
        eng_q[1] = '{16'h0021, 16'h0022, 16'h0023};
        eng_q[2] = '{16'h0024};
        apply();
        clear_logs();
        cyc(5);
        chk("seq_pop0", 64'(pop_log[0]), 64'h2);
        chk("seq_pop1", 64'(pop_log[1]), 64'h2);
        chk("seq_pop2", 64'(pop_log[2]), 64'h2);
        chk("seq_pop3", 64'(pop_log[3]), 64'h4);

        // Memory priority over engine 0.
        do_flush();
        mode_v = 1'b1;
        mem_q    = '{16'h0031};
        eng_q[0] = '{16'h0032};
        apply();
        clear_logs();
        cyc(3);
        chk("mem_ready_t0", 64'(mr_log[0]),  64'd1);
        chk("mem_pop_t0",   64'(pop_log[0]), 64'h0);
        chk("mem_pop_t1",   64'(pop_log[1]), 64'h1);

        // Backpressure: MStack full, 10 literals offered to an 8-deep FIFO.
        do_flush();
        full_v = 5'b10000;
        eng_q[0] = '{16'h0041, 16'h0042, 16'h0043, 16'h0044, 16'h0045};
        eng_q[1] = '{16'h0046, 16'h0047, 16'h0048, 16'h0049, 16'h004A};
        apply();
        cyc(10);
        #1;
        chk("bp_count_full", 64'(bus.count),   64'd8);
        chk("bp_pop_held",   64'(bus.eng_pop), 64'h0);
        full_v = '0;
        apply();
        clear_logs();
        cyc(14);
        chk("bp_pushes",  64'(n_pushes()), 64'd10);
        chk("bp_lit0",    64'(lit_log[0]), 64'h0041);
        chk("bp_lit1",    64'(lit_log[1]), 64'h0046);
        chk("bp_lit9",    64'(lit_log[9]), 64'h004A);
        chk("bp_empty",   64'(bus.count),  64'd0);

        // Conflict: 0x0005 buffered, then 0x8005 granted.
        do_flush();
        full_v = 5'b10000;
        eng_q[0] = '{16'h0005, 16'h8005};
        apply();
        cyc(2);
        #1;
        chk("cf_conflict", 64'(bus.conflict), 64'd1);
        chk("cf_count",    64'(bus.count),    64'd1);
        eng_q[2] = '{16'h0009};
        full_v = '0;
        apply();
        clear_logs();
        cyc(4);
        chk("cf_no_push", 64'(n_pushes()), 64'd0);
        chk("cf_no_pop",  64'(n_pops()),   64'd0);
        do_flush();
        #1;
        chk("cf_flush_count",    64'(bus.count),    64'd0);
        chk("cf_flush_conflict", 64'(bus.conflict), 64'd0);
        cyc(3);

        // Duplicate literal: dropped only when dedup is built in.
        do_flush();
        full_v = 5'b10000;
        eng_q[0] = '{16'h0007, 16'h0007};
        apply();
        cyc(3);
        #1;
        chk("dup_count", 64'(bus.count), DEDUP ? 64'd1 : 64'd2);
        full_v = '0;
        apply();
        clear_logs();
        cyc(4);
        chk("dup_pushes", 64'(n_pushes()), DEDUP ? 64'd1 : 64'd2);

        // Null-index literals are popped and discarded.
        do_flush();
        eng_q[3] = '{16'h0000, 16'h8000};
        apply();
        clear_logs();
        cyc(3);
        chk("null_pops",   64'(n_pops()),   64'd2);
        chk("null_pushes", 64'(n_pushes()), 64'd0);
        chk("null_count",  64'(bus.count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
